pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central pipeline controller that drives the write-enable and flush inputs of every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write-enable.
It is the producer side of the idex WEN/flush handshake. It resolves four hazard classes:
- data-memory wait
- instruction-fetch miss
- load-use hazard
- EX-stage control redirect
It also sequences halt drain and keeps stall and flush statistics. It sits beside the datapath in the pipelined CPU and consumes hazard indicators from the ID, EX and MEM stages.

Parameters:
CNT_W, 32, width of the saturating performance counters.

Ports:
CLK  in  1  system clock, rising edge.
nRST  in  1  asynchronous active-low reset.
ihit  in  1  instruction fetch complete this cycle.
dhit  in  1  data access complete this cycle.
exmem_MemRead  in  1  load in MEM stage.
exmem_MemWrite  in  1  store in MEM stage.
idex_MemRead  in  1  load in EX stage.
idex_rt  in  5  destination of the EX-stage load.
ifid_rs  in  5  source register of the ID-stage instruction.
ifid_rt  in  5  source register of the ID-stage instruction.
ex_redirect  in  1  branch taken or jump resolved in EX (PC must change).
memwb_halt  in  1  halt instruction has reached WB.
pc_WEN  out  1  PC update enable.
ifid_WEN  out  1  IF/ID write enable.
ifid_flush  out  1  IF/ID flush (bubble insert).
idex_WEN  out  1  ID/EX write enable.
idex_flush  out  1  ID/EX flush.
exmem_WEN  out  1  EX/MEM write enable.
exmem_flush  out  1  EX/MEM flush.
memwb_WEN  out  1  MEM/WB write enable.
halt  out  1  sticky CPU halted.
stall_cycles  out  CNT_W  cycles with pc_WEN=0 while not halted; saturates at all-ones.
flush_count  out  CNT_W  redirect flushes issued; saturates.

Behaviour:
- State register: BOOT, RUN, DWAIT, HALTED. Reset (async, nRST low) → BOOT. Counters cleared to 0, halt cleared to 0.
- Outputs are combinational from the current state and inputs. In BOOT and while nRST is low, all WEN and flush outputs are 0.
- BOOT: lasts exactly one cycle, then RUN. This gives the caches one clean cycle after reset.
- RUN, priority highest first:
  1. memwb_halt=1: all WEN 0, all flush 0; next state HALTED.
  2. dmem pending and not done (exmem_MemRead or exmem_MemWrite, and dhit=0): freeze the whole pipe (all WEN 0, all flush 0); next state DWAIT.
  3. ex_redirect=1: pc_WEN=1, ifid_flush=1, idex_flush=1, all other WEN 1; flush_count increments. The redirect overrides any simultaneous load-use or ihit=0 condition.
  4. Load-use: idex_MemRead=1 and idex_rt≠0 and (idex_rt==ifid_rs or idex_rt==ifid_rt). Outputs: pc_WEN=0, ifid_WEN=0, idex_flush=1, exmem_WEN=1, memwb_WEN=1. This lasts exactly one cycle, because the flushed ID/EX clears the condition.
  5. ihit=0: pc_WEN=0, ifid_flush=1; downstream WENs 1, so older instructions drain.
  6. Otherwise: all WEN 1, all flush 0.
- DWAIT: all WEN 0 until dhit=1.
  - In the dhit=1 cycle, the RUN priority rules 3–6 are evaluated and the state returns to RUN. The completing access advances on that same edge.
  - memwb_halt in DWAIT is ignored, because it cannot change while frozen.
- HALTED: all WEN 0, all flush 0, halt=1. The state is absorbing; only reset exits it.
- Flush dominates WEN: whenever a register's flush is 1, its WEN is also driven 1.
- stall_cycles increments on each rising edge with pc_WEN=0 in states RUN and DWAIT. It holds in BOOT and HALTED.
- Both counters saturate at 2^CNT_W−1 with no wrap.
- Reset mid-stall or mid-DWAIT returns immediately to BOOT with outputs 0 and no residual stall.

Decomposition:
- Shared package cpu_types_pkg gains:
  - ctrl_state_t enum (BOOT, RUN, DWAIT, HALTED);
  - hazard_t one-hot struct (dwait, redirect, loaduse, imiss) for debug visibility.
- One sub-module, sat_counter (parameter width; inc, value; async active-low reset), instantiated twice for the counters.

Test Plan:
- Reset then idle with ihit=1: cycle 0 after reset all outputs 0; cycle 1 all WEN 1, flushes 0, stall_cycles=0.
- Load-use: idex_MemRead=1, idex_rt=5, ifid_rs=5 → exactly one cycle of pc_WEN=0, ifid_WEN=0, idex_flush=1; stall_cycles=1. Repeat with idex_rt=0 → no stall.
- Data wait: exmem_MemRead=1, dhit=0 for 3 cycles then 1 → 3 cycles all WEN 0; 4th cycle all WEN 1; stall_cycles=3.
- Redirect with simultaneous load-use and ihit=0 → pc_WEN=1, ifid_flush=1, idex_flush=1; flush_count=1, stall_cycles unchanged.
- Halt: memwb_halt=1 → halt=1 next cycle and stays 1 despite ihit/ex_redirect toggling; all WEN 0; counters frozen; nRST pulse clears halt.
- Saturation with CNT_W=4: hold ihit=0 for 20 cycles → stall_cycles sticks at 15.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU control types and hazard helpers
package cpu_types_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    DWAIT  = 2'd2,
    HALTED = 2'd3
  } ctrl_state_t;

  // One-hot, priority-resolved view of the hazard acted on this cycle
  typedef struct packed {
    logic dwait;
    logic redirect;
    logic loaduse;
    logic imiss;
  } hazard_t;

  function automatic logic load_use(input logic       mem_read,
                                    input logic [4:0] ex_rt,
                                    input logic [4:0] id_rs,
                                    input logic [4:0] id_rt);
    return mem_read && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter, sticks at all-ones
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      value <= '0;
    end else if (inc && (value != {WIDTH{1'b1}})) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline WEN/flush controller with halt drain and stall stats
module pipeline_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             exmem_MemRead,
  input  logic             exmem_MemWrite,
  input  logic             idex_MemRead,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ex_redirect,
  input  logic             memwb_halt,
  output logic             pc_WEN,
  output logic             ifid_WEN,
  output logic             ifid_flush,
  output logic             idex_WEN,
  output logic             idex_flush,
  output logic             exmem_WEN,
  output logic             exmem_flush,
  output logic             memwb_WEN,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  ctrl_state_t state, next_state;
  hazard_t     haz;
  logic        ifid_we, idex_we, exmem_we;
  logic        stall_inc, flush_inc;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= BOOT;
    end else begin
      state <= next_state;
    end
  end

  // In DWAIT the pending access is known to be outstanding; only dhit matters
  always_comb begin
    haz = '0;
    if ((state == DWAIT) ? !dhit : ((exmem_MemRead || exmem_MemWrite) && !dhit)) begin
      haz.dwait = 1'b1;
    end else if (ex_redirect) begin
      haz.redirect = 1'b1;
    end else if (load_use(idex_MemRead, idex_rt, ifid_rs, ifid_rt)) begin
      haz.loaduse = 1'b1;
    end else if (!ihit) begin
      haz.imiss = 1'b1;
    end
  end

  always_comb begin
    next_state  = state;
    pc_WEN      = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_we     = 1'b0;
    idex_flush  = 1'b0;
    exmem_we    = 1'b0;
    exmem_flush = 1'b0;
    memwb_WEN   = 1'b0;
    flush_inc   = 1'b0;
    case (state)
      BOOT: next_state = RUN;
      RUN, DWAIT: begin
        if ((state == RUN) && memwb_halt) begin
          next_state = HALTED;
        end else if (haz.dwait) begin
          next_state = DWAIT;
        end else begin
          next_state = RUN;
          {pc_WEN, ifid_we, idex_we, exmem_we, memwb_WEN} = 5'b11111;
          if (haz.redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_inc  = 1'b1;
          end else if (haz.loaduse) begin
            pc_WEN     = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
          end else if (haz.imiss) begin
            pc_WEN     = 1'b0;
            ifid_flush = 1'b1;
          end
        end
      end
      default: next_state = HALTED;
    endcase
  end

  // A flushed register must also be written so the bubble actually lands
  assign ifid_WEN  = ifid_we  | ifid_flush;
  assign idex_WEN  = idex_we  | idex_flush;
  assign exmem_WEN = exmem_we | exmem_flush;

  assign halt      = (state == HALTED);
  assign stall_inc = ((state == RUN) || (state == DWAIT)) && !pc_WEN;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (stall_inc),
    .value (stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (flush_inc),
    .value (flush_count)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed vector bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             ihit, dhit, exmem_MemRead, exmem_MemWrite, idex_MemRead;
  logic [4:0]       idex_rt, ifid_rs, ifid_rt;
  logic             ex_redirect, memwb_halt;
  logic             pc_WEN, ifid_WEN, ifid_flush, idex_WEN, idex_flush;
  logic             exmem_WEN, exmem_flush, memwb_WEN, halt;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic [7:0]       outs;

  int vectors = 0;
  int miscompares = 0;

  // {pc, ifid_WEN, ifid_flush, idex_WEN, idex_flush, exmem_WEN, exmem_flush, memwb_WEN}
  localparam logic [7:0] O_FREEZE   = 8'b0000_0000;
  localparam logic [7:0] O_NORMAL   = 8'b1101_0101;
  localparam logic [7:0] O_REDIRECT = 8'b1111_1101;
  localparam logic [7:0] O_LOADUSE  = 8'b0001_1101;
  localparam logic [7:0] O_IMISS    = 8'b0111_0101;

  typedef struct {
    string      name;
    logic       ihit, dhit, mrd, mwr, idex_mr;
    logic [4:0] ex_rt, rs, rt;
    logic       redir;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[12];

  always #5 CLK = ~CLK;

  assign outs = {pc_WEN, ifid_WEN, ifid_flush, idex_WEN, idex_flush, exmem_WEN, exmem_flush, memwb_WEN};

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .ihit           (ihit),
    .dhit           (dhit),
    .exmem_MemRead  (exmem_MemRead),
    .exmem_MemWrite (exmem_MemWrite),
    .idex_MemRead   (idex_MemRead),
    .idex_rt        (idex_rt),
    .ifid_rs        (ifid_rs),
    .ifid_rt        (ifid_rt),
    .ex_redirect    (ex_redirect),
    .memwb_halt     (memwb_halt),
    .pc_WEN         (pc_WEN),
    .ifid_WEN       (ifid_WEN),
    .ifid_flush     (ifid_flush),
    .idex_WEN       (idex_WEN),
    .idex_flush     (idex_flush),
    .exmem_WEN      (exmem_WEN),
    .exmem_flush    (exmem_flush),
    .memwb_WEN      (memwb_WEN),
    .halt           (halt),
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b0; exmem_MemRead = 1'b0; exmem_MemWrite = 1'b0;
    idex_MemRead = 1'b0; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    ex_redirect = 1'b0; memwb_halt = 1'b0;
  endtask

  // Reset, then pass through the BOOT cycle into RUN
  task automatic reset_to_run();
    idle_inputs();
    nRST = 1'b0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    step();
  endtask

  initial begin
    tbl[0]  = '{"idle",          1, 0, 0, 0, 0, 5'd0,  5'd0, 5'd0,  0, O_NORMAL};
    tbl[1]  = '{"imiss",         0, 0, 0, 0, 0, 5'd0,  5'd0, 5'd0,  0, O_IMISS};
    tbl[2]  = '{"lu_rs",         1, 0, 0, 0, 1, 5'd5,  5'd5, 5'd2,  0, O_LOADUSE};
    tbl[3]  = '{"lu_rt",         1, 0, 0, 0, 1, 5'd7,  5'd1, 5'd7,  0, O_LOADUSE};
    tbl[4]  = '{"lu_r0",         1, 0, 0, 0, 1, 5'd0,  5'd0, 5'd0,  0, O_NORMAL};
    tbl[5]  = '{"lu_noread",     1, 0, 0, 0, 0, 5'd5,  5'd5, 5'd5,  0, O_NORMAL};
    tbl[6]  = '{"redir_lu_miss", 0, 0, 0, 0, 1, 5'd5,  5'd5, 5'd0,  1, O_REDIRECT};
    tbl[7]  = '{"lu_over_miss",  0, 0, 0, 0, 1, 5'd9,  5'd3, 5'd9,  0, O_LOADUSE};
    tbl[8]  = '{"load_hit",      1, 1, 1, 0, 0, 5'd0,  5'd0, 5'd0,  0, O_NORMAL};
    tbl[9]  = '{"store_hit_miss",0, 1, 0, 1, 0, 5'd0,  5'd0, 5'd0,  0, O_IMISS};
    tbl[10] = '{"lu_r31",        1, 0, 0, 0, 1, 5'd31, 5'd4, 5'd31, 0, O_LOADUSE};
    tbl[11] = '{"redir",         1, 0, 0, 0, 0, 5'd0,  5'd0, 5'd0,  1, O_REDIRECT};

    // Reset state and BOOT cycle
    idle_inputs();
    nRST = 1'b0;
    #3;
    chk("rst_outs", {24'd0, outs}, {24'd0, O_FREEZE});
    chk("rst_halt", {31'd0, halt}, 32'd0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    #1;
    chk("boot_outs", {24'd0, outs}, {24'd0, O_FREEZE});
    step();
    chk("run_outs", {24'd0, outs}, {24'd0, O_NORMAL});
    chk("run_stall", {28'd0, stall_cycles}, 32'd0);

    // Single-cycle RUN decisions
    for (int i = 0; i < 12; i++) begin
      ihit = tbl[i].ihit; dhit = tbl[i].dhit;
      exmem_MemRead = tbl[i].mrd; exmem_MemWrite = tbl[i].mwr;
      idex_MemRead = tbl[i].idex_mr; idex_rt = tbl[i].ex_rt;
      ifid_rs = tbl[i].rs; ifid_rt = tbl[i].rt; ex_redirect = tbl[i].redir;
      #1;
      chk(tbl[i].name, {24'd0, outs}, {24'd0, tbl[i].exp});
      step();
    end
    idle_inputs();
    chk("tbl_stall", {28'd0, stall_cycles}, 32'd6);
    chk("tbl_flush", {28'd0, flush_count}, 32'd2);

    // Load-use lasts one cycle once ID/EX is bubbled
    reset_to_run();
    chk("rst_clr_stall", {28'd0, stall_cycles}, 32'd0);
    idex_MemRead = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
    #1;
    chk("lu_cyc", {24'd0, outs}, {24'd0, O_LOADUSE});
    step();
    idex_MemRead = 1'b0; idex_rt = 5'd0;
    #1;
    chk("lu_after", {24'd0, outs}, {24'd0, O_NORMAL});
    chk("lu_stall", {28'd0, stall_cycles}, 32'd1);

    // Data wait: three frozen cycles, then release on dhit
    reset_to_run();
    exmem_MemRead = 1'b1; dhit = 1'b0;
    #1;
    chk("dw_c0", {24'd0, outs}, {24'd0, O_FREEZE});
    step();
    memwb_halt = 1'b1;
    #1;
    chk("dw_c1_halt_ign", {24'd0, outs}, {24'd0, O_FREEZE});
    step();
    memwb_halt = 1'b0;
    chk("dw_no_halt", {31'd0, halt}, 32'd0);
    chk("dw_c2", {24'd0, outs}, {24'd0, O_FREEZE});
    step();
    dhit = 1'b1;
    #1;
    chk("dw_release", {24'd0, outs}, {24'd0, O_NORMAL});
    step();
    exmem_MemRead = 1'b0; dhit = 1'b0;
    chk("dw_stall", {28'd0, stall_cycles}, 32'd3);
    chk("dw_run", {24'd0, outs}, {24'd0, O_NORMAL});

    // Halt: sticky, absorbing, counters frozen; the halting cycle itself stalls
    reset_to_run();
    ex_redirect = 1'b1;
    step();
    ex_redirect = 1'b0;
    memwb_halt = 1'b1;
    #1;
    chk("halt_cyc", {24'd0, outs}, {24'd0, O_FREEZE});
    step();
    memwb_halt = 1'b0;
    chk("halt_set", {31'd0, halt}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      ihit = i[0]; ex_redirect = ~i[0];
      #1;
      chk("halt_outs", {24'd0, outs}, {24'd0, O_FREEZE});
      step();
      chk("halt_sticky", {31'd0, halt}, 32'd1);
    end
    chk("halt_stall", {28'd0, stall_cycles}, 32'd1);
    chk("halt_flush", {28'd0, flush_count}, 32'd1);
    nRST = 1'b0;
    #1;
    chk("halt_rst", {31'd0, halt}, 32'd0);
    chk("halt_rst_outs", {24'd0, outs}, {24'd0, O_FREEZE});

    // Saturation of both counters at 15
    reset_to_run();
    ihit = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("sat_outs", {24'd0, outs}, {24'd0, O_IMISS});
    chk("sat_stall", {28'd0, stall_cycles}, 32'd15);
    ihit = 1'b1; ex_redirect = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("sat_flush", {28'd0, flush_count}, 32'd15);
    chk("sat_stall_hold", {28'd0, stall_cycles}, 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
